turn_signal_ctrl: RTL and testbench

Parametrised turn-signal and hazard-light controller for the car model: drives N lamps per side with timed blinking, an optional sequential "chase" pattern and hazard mode. Sits between the driver-input decode (`mode`, `turn_left`, `turn_right`) and the board LED pins, and replaces the fixed steady-on side-light outputs.

---
 rtl/turn_signal_ctrl.sv | 107 ++++++++++
 tb/tb_turn_signal_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard controller: N lamps per side, timed chase or flash pattern.
// State, divider and frame counter are registered; lamp outputs decode from them only.
module turn_signal_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int N        = 4,
    parameter bit SEQ      = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic         turn_left,
    input  logic         turn_right,
    output logic [N-1:0] left_light,
    output logic [N-1:0] right_light,
    output logic         hazard
);

    localparam int DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FRAME_W    = (N > 0) ? $clog2(N + 1) : 1;
    localparam int LAST_FRAME = SEQ ? N : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(LAST_FRAME);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZARD
    } state_t;

    state_t               state, state_nxt, req;
    logic [DIV_W-1:0]     div, div_nxt;
    logic [FRAME_W-1:0]   frame, frame_nxt;
    logic                 tick;
    logic                 restart;
    logic [N-1:0]         pat;

    always_comb begin
        if (mode == 2'b00)                req = IDLE;
        else if (turn_left && turn_right) req = HAZARD;
        else if (turn_left)               req = LEFT;
        else if (turn_right)              req = RIGHT;
        else                              req = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is asynchronous and clears all state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= '0;
            frame <= '0;
        end else begin
            state <= state_nxt;
            div   <= div_nxt;
            frame <= frame_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the if/case chain can infer a latch.
    always_comb begin
        state_nxt = req;
        div_nxt   = div;
        frame_nxt = frame;
        tick      = (div == DIV_LAST);
        restart   = (req != state);

        // A restart wins over a coincident tick, so the new frame 0 lasts a full TICK_DIV.
        if (restart || state == IDLE) begin
            div_nxt   = '0;
            frame_nxt = '0;
        end else if (tick) begin
            div_nxt   = '0;
            frame_nxt = (frame == FRAME_LAST) ? '0 : frame + FRAME_W'(1);
        end else begin
            div_nxt   = div + DIV_W'(1);
        end
    end

    always_comb begin
        pat = '0;
        if (SEQ) begin
            for (int i = 0; i < N; i++) begin
                if (int'(frame) < N && i <= int'(frame)) pat[i] = 1'b1;
            end
        end else begin
            pat = (frame == '0) ? '1 : '0;
        end

        left_light  = '0;
        right_light = '0;
        hazard      = 1'b0;
        case (state)
            LEFT:   left_light = pat;
            RIGHT:  right_light = pat;
            HAZARD: begin
                left_light  = pat;
                right_light = pat;
                hazard      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Self-checking bench for turn_signal_ctrl: directed scenarios plus randomized
// request sequences compared against a time-since-restart reference model.
module tb_turn_signal_ctrl;

    localparam int TD = 4;
    localparam int NL = 3;

    localparam int M_IDLE   = 0;
    localparam int M_LEFT   = 1;
    localparam int M_RIGHT  = 2;
    localparam int M_HAZARD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          turn_left = 1'b0;
    logic          turn_right = 1'b0;
    logic [NL-1:0] left_light, right_light;
    logic          hazard;

    logic          f_left = 1'b0;
    logic          f_right = 1'b0;
    logic [NL-1:0] f_left_light, f_right_light;
    logic          f_hazard;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: active request and cycles elapsed since it started.
    int m_st = M_IDLE;
    int m_t  = 0;

    always #5 clk = ~clk;

    turn_signal_ctrl #(.TICK_DIV(TD), .N(NL), .SEQ(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .turn_left(turn_left), .turn_right(turn_right),
        .left_light(left_light), .right_light(right_light), .hazard(hazard)
    );

    turn_signal_ctrl #(.TICK_DIV(1), .N(NL), .SEQ(1'b0)) u_flash (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .turn_left(f_left), .turn_right(f_right),
        .left_light(f_left_light), .right_light(f_right_light), .hazard(f_hazard)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [NL-1:0] chase(input int t);
        int f;
        f = (t / TD) % (NL + 1);
        return (f < NL) ? NL'((1 << (f + 1)) - 1) : '0;
    endfunction

    function automatic int decode(input logic [1:0] md, input logic l, input logic r);
        if (md == 2'b00) return M_IDLE;
        if (l && r)      return M_HAZARD;
        if (l)           return M_LEFT;
        if (r)           return M_RIGHT;
        return M_IDLE;
    endfunction

    // Apply inputs at the falling edge, advance the model at the rising edge, check 1 time unit later.
    task automatic step(input logic [1:0] md, input logic l, input logic r);
        int rq;
        @(negedge clk);
        mode = md;
        turn_left = l;
        turn_right = r;
        @(posedge clk);
        if (!rst_n) begin
            m_st = M_IDLE;
            m_t  = 0;
        end else begin
            rq = decode(md, l, r);
            if (rq != m_st) begin
                m_st = rq;
                m_t  = 0;
            end else if (m_st != M_IDLE) begin
                m_t++;
            end
        end
        #1;
        check("left",   32'(left_light),
              32'((m_st == M_LEFT || m_st == M_HAZARD) ? chase(m_t) : '0));
        check("right",  32'(right_light),
              32'((m_st == M_RIGHT || m_st == M_HAZARD) ? chase(m_t) : '0));
        check("hazard", 32'(hazard), 32'(m_st == M_HAZARD));
    endtask

    initial begin
        #1;
        check("reset_left",   32'(left_light), 32'h0);
        check("reset_right",  32'(right_light), 32'h0);
        check("reset_hazard", 32'(hazard), 32'h0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Left chase, then asynchronous reset mid-blink.
        for (int i = 0; i < 6; i++) step(2'b01, 1'b1, 1'b0);
        check("chase_f1", 32'(left_light), 32'h3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_left",  32'(left_light), 32'h0);
        check("async_rst_right", 32'(right_light), 32'h0);
        step(2'b01, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) step(2'b00, 1'b0, 1'b0);

        // Full left chase sequence from a fresh request.
        for (int i = 0; i < 20; i++) begin
            step(2'b01, 1'b1, 1'b0);
            if (i == 0)  check("chase_c1",  32'(left_light), 32'h1);
            if (i == 4)  check("chase_c5",  32'(left_light), 32'h3);
            if (i == 8)  check("chase_c9",  32'(left_light), 32'h7);
            if (i == 12) check("chase_c13", 32'(left_light), 32'h0);
            if (i == 16) check("chase_c17", 32'(left_light), 32'h1);
        end

        // Hazard restart from left frame 2.
        while ((m_t / TD) % (NL + 1) != 2) step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        check("haz_start_left",  32'(left_light), 32'h1);
        check("haz_start_right", 32'(right_light), 32'h1);
        check("haz_start_flag",  32'(hazard), 32'h1);
        for (int i = 0; i < 3 * (NL + 1) * TD; i++) begin
            step(2'b01, 1'b1, 1'b1);
            check("haz_in_phase", 32'(left_light), 32'(right_light));
        end

        // Side switch on the tick edge.
        for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0);
        while (m_t % TD != TD - 1) step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b0, 1'b1);
        check("switch_right", 32'(right_light), 32'h1);
        check("switch_left",  32'(left_light), 32'h0);
        for (int i = 0; i < TD; i++) step(2'b01, 1'b0, 1'b1);
        check("switch_frame1", 32'(right_light), 32'h3);

        // Power off during hazard, then power back on.
        for (int i = 0; i < 7; i++) step(2'b10, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b1);
        check("poweroff_left",  32'(left_light), 32'h0);
        check("poweroff_right", 32'(right_light), 32'h0);
        check("poweroff_haz",   32'(hazard), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        check("poweron_left", 32'(left_light), 32'h1);

        // Randomized request sequences, including single-cycle glitches.
        for (int s = 0; s < 150; s++) begin
            logic [1:0] md;
            logic l, r;
            int len;
            md  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            l   = 1'($urandom);
            r   = 1'($urandom);
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) step(md, l, r);
        end

        // Flash variant: TICK_DIV=1, SEQ=0, right held.
        step(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        f_right = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("flash_right", 32'(f_right_light), (k % 2 == 0) ? 32'h7 : 32'h0);
            check("flash_left",  32'(f_left_light), 32'h0);
            check("flash_haz",   32'(f_hazard), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
